// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between the sample FIFO and fifo_uart_tx.
// The transmitter is the master: it issues the read strobe and consumes
// the empty flag and read data. The FIFO side uses the slave modport.
interface fifo_uart_tx_if;
  logic        rd_o;
  logic        empty_i;
  logic [15:0] dato_i;

  modport master (output rd_o, input empty_i, input dato_i);
  modport slave  (input rd_o, output empty_i, output dato_i);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 16-bit samples from the sample FIFO to the PC as
// UART bytes, high byte first, each byte sent LSB first.
// A burst starts on a rising edge of send_i. It runs until the FIFO is
// empty, or until MAX_WORDS words have gone out (MAX_WORDS = 0 means no
// limit).
// Optional feature macro: FIFO_UART_TX_PARITY_EN. When defined, an
// even-parity bit is inserted between the data bits and the stop bit
// (8E1, 11 bit times per byte). Otherwise the line format is 8N1.
module fifo_uart_tx #(
  parameter int CLK_DIV   = 868,
  parameter int MAX_WORDS = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           send_i,
  fifo_uart_tx_if.master fifo,
  output logic           tx_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam logic [15:0] TICK_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WORD_LIMIT = 16'(MAX_WORDS);
  localparam bit          LIMIT_EN   = (MAX_WORDS != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        send_q;
  logic        start;
  logic [15:0] word_q;
  logic        high_sel;
  logic [2:0]  bit_cnt;
  logic [15:0] tick_cnt;
  logic [15:0] word_cnt;
  logic [15:0] word_cnt_inc;
  logic        tick_last;
  logic        burst_end;
  logic        in_bit;
  logic [7:0]  cur_byte;
  logic        rd_c;
  logic        tx_c;
  logic        busy_c;
  logic        done_c;

  assign start        = send_i & ~send_q;
  assign tick_last    = (tick_cnt == TICK_LAST);
  assign cur_byte     = high_sel ? word_q[15:8] : word_q[7:0];
  assign word_cnt_inc = word_cnt + 16'd1;
  assign burst_end    = (LIMIT_EN && (word_cnt_inc == WORD_LIMIT)) || fifo.empty_i;

  // State register; a reset anywhere, even mid-frame, drops back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode. Outputs default to the idle line levels.
  always_comb begin
    state_next = state;
    rd_c       = 1'b0;
    tx_c       = 1'b1;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    in_bit     = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (start) state_next = fifo.empty_i ? DONE : READ;
      end
      READ: begin
        rd_c       = 1'b1;
        state_next = LATCH;
      end
      LATCH: state_next = START;
      START: begin
        tx_c   = 1'b0;
        in_bit = 1'b1;
        if (tick_last) state_next = DATA;
      end
      DATA: begin
        tx_c   = cur_byte[bit_cnt];
        in_bit = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        if (tick_last && (bit_cnt == 3'd7)) state_next = PARITY;
`else
        if (tick_last && (bit_cnt == 3'd7)) state_next = STOP;
`endif
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_c   = ^cur_byte;
        in_bit = 1'b1;
        if (tick_last) state_next = STOP;
      end
`endif
      STOP: begin
        in_bit = 1'b1;
        if (tick_last) begin
          if (high_sel)       state_next = START;
          else if (burst_end) state_next = DONE;
          else                state_next = READ;
        end
      end
      DONE: begin
        busy_c     = 1'b0;
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy_c     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign fifo.rd_o = rd_c;
  assign tx_o      = tx_c;
  assign busy_o    = busy_c;
  assign done_o    = done_c;

  // Datapath. It holds the edge detector, the bit timer, the bit and byte
  // selection, the latched word and the per-burst word count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      send_q   <= 1'b0;
      word_q   <= 16'd0;
      high_sel <= 1'b0;
      bit_cnt  <= 3'd0;
      tick_cnt <= 16'd0;
      word_cnt <= 16'd0;
    end else begin
      send_q <= send_i;

      if (in_bit && !tick_last) tick_cnt <= tick_cnt + 16'd1;
      else                      tick_cnt <= 16'd0;

      if (state == LATCH) begin
        word_q   <= fifo.dato_i;
        high_sel <= 1'b1;
      end else if ((state == STOP) && tick_last && high_sel) begin
        high_sel <= 1'b0;
      end

      if (state == START)                  bit_cnt <= 3'd0;
      else if ((state == DATA) && tick_last) bit_cnt <= bit_cnt + 3'd1;

      if ((state == STOP) && tick_last && !high_sel) word_cnt <= word_cnt_inc;
      else if (state == DONE)                        word_cnt <= 16'd0;
    end
  end

endmodule
